// File: rtl/mdu_pkg.sv
// mdu_pkg: shared FSM/operation enums and default sizing for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  typedef enum logic {OP_MULT, OP_DIV} op_t;
  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = $clog2(MDU_WIDTH);
endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/result bundle (start_mult, start_div, a, b -> hi, lo, busy, done, div_zero); master drives requests, slave is the engine
interface mdu_if import mdu_pkg::*; #(parameter int WIDTH = MDU_WIDTH);
  logic start_mult;
  logic start_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic busy;
  logic done;
  logic div_zero;
  modport master(output start_mult, start_div, a, b, input hi, lo, busy, done, div_zero);
  modport slave(input start_mult, start_div, a, b, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-divide step (rem, quo, divisor -> rem_nxt, quo_nxt); rem < divisor keeps the trial result within WIDTH+1 bits
module mdu_div_step import mdu_pkg::*; #(parameter int WIDTH = MDU_WIDTH) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial = shifted - {1'b0, divisor};
  assign rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed multiply/divide, one bit per clock (clock, reset, bus: mdu_if.slave); define MDU_EARLY_ZERO_EN for the zero-operand fast path
module mult_div_unit import mdu_pkg::*; #(parameter int WIDTH = MDU_WIDTH) (
  input logic clock,
  input logic reset,
  mdu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nxt;
  op_t op;
  logic sa, sb, go_mult, go_div, dz, fast;
  logic [WIDTH-1:0] mb, ma_in, mb_in, rem_nxt, quo_nxt, quo_f, rem_f, hi, lo;
  logic [2*WIDTH-1:0] acc, mult_nxt, prod;
  logic [WIDTH:0] msum;
  logic [CW-1:0] cnt;
  logic done, div_zero;
  mdu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem(acc[2*WIDTH-1:WIDTH]),
    .quo(acc[WIDTH-1:0]),
    .divisor(mb),
    .rem_nxt(rem_nxt),
    .quo_nxt(quo_nxt)
  );
  always_comb begin
    ma_in = bus.a[WIDTH-1] ? -bus.a : bus.a;
    mb_in = bus.b[WIDTH-1] ? -bus.b : bus.b;
    go_mult = bus.start_mult;
    go_div = !bus.start_mult && bus.start_div && bus.b != '0;
    dz = !bus.start_mult && bus.start_div && bus.b == '0;
`ifdef MDU_EARLY_ZERO_EN
    fast = go_mult ? (bus.a == '0 || bus.b == '0) : bus.a == '0;
`else
    fast = 1'b0;
`endif
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : '0);
    mult_nxt = {msum, acc[WIDTH-1:1]};
    prod = (sa ^ sb) ? -acc : acc;
    quo_f = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_f = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    state_nxt = state == IDLE ? ((go_mult || go_div) ? (fast ? FINISH : RUN) : IDLE) :
                state == RUN ? (cnt == CW'(WIDTH - 1) ? FINISH : RUN) : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      op <= OP_MULT;
      sa <= 1'b0;
      sb <= 1'b0;
      mb <= '0;
      acc <= '0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      done <= state == FINISH;
      div_zero <= state == IDLE && dz;
      cnt <= state == IDLE ? '0 : cnt + CW'(1);
      if (state == IDLE && (go_mult || go_div)) begin
        op <= go_mult ? OP_MULT : OP_DIV;
        sa <= bus.a[WIDTH-1];
        sb <= bus.b[WIDTH-1];
        mb <= mb_in;
        acc <= fast ? '0 : {{WIDTH{1'b0}}, ma_in};
      end
      if (state == RUN) acc <= op == OP_MULT ? mult_nxt : {rem_nxt, quo_nxt};
      if (state == FINISH) {hi, lo} <= op == OP_MULT ? prod : {rem_f, quo_f};
    end
  end
  assign bus.hi = hi;
  assign bus.lo = lo;
  assign bus.busy = state != IDLE;
  assign bus.done = done;
  assign bus.div_zero = div_zero;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with hand-computed results for mult_div_unit
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  int lat, bcnt, dcnt;
  mdu_if #(.WIDTH(32)) bus();
  mult_div_unit #(.WIDTH(32)) dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic run_op(input logic m, input logic d, input logic [31:0] aa, input logic [31:0] bb, output int l, output int bc);
    @(negedge clk);
    bus.start_mult = m;
    bus.start_div = d;
    bus.a = aa;
    bus.b = bb;
    @(posedge clk);
    #1;
    bus.start_mult = 1'b0;
    bus.start_div = 1'b0;
    l = 1;
    bc = 0;
    while (bus.done !== 1'b1 && l < 60) begin
      if (bus.busy) bc++;
      @(posedge clk);
      #1;
      l++;
    end
  endtask
  typedef struct {logic m; logic [31:0] a; logic [31:0] b; logic [31:0] hi; logic [31:0] lo;} vec_t;
  vec_t vecs[6] = '{
    '{1'b1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB},
    '{1'b1, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0, 32'd30},
    '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0},
    '{1'b0, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD},
    '{1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000}
  };
  initial begin
    bus.start_mult = 1'b0;
    bus.start_div = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hilo", {bus.hi, bus.lo}, 64'h0);
    chk("rst_flags", {61'h0, bus.busy, bus.done, bus.div_zero}, 64'h0);
    rst = 1'b0;
    foreach (vecs[i]) begin
      run_op(vecs[i].m, !vecs[i].m, vecs[i].a, vecs[i].b, lat, bcnt);
      chk($sformatf("lat%0d", i), lat, 34);
      chk($sformatf("busy%0d", i), bcnt, 33);
      chk($sformatf("busy_done%0d", i), bus.busy, 1'b0);
      chk($sformatf("res%0d", i), {bus.hi, bus.lo}, {vecs[i].hi, vecs[i].lo});
    end
    @(negedge clk);
    bus.start_div = 1'b1;
    bus.a = 32'd5;
    bus.b = 32'd0;
    @(posedge clk);
    #1;
    bus.start_div = 1'b0;
    chk("dz_pulse", bus.div_zero, 1'b1);
    chk("dz_busy", bus.busy, 1'b0);
    dcnt = 0;
    bcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) dcnt++;
      if (bus.busy || bus.div_zero) bcnt++;
    end
    chk("dz_no_done", dcnt, 0);
    chk("dz_quiet", bcnt, 0);
    chk("dz_hold", {bus.hi, bus.lo}, {32'h0, 32'h80000000});
    @(negedge clk);
    bus.start_mult = 1'b1;
    bus.a = 32'd3;
    bus.b = 32'd3;
    @(posedge clk);
    #1;
    bus.start_mult = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", bus.busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_hilo", {bus.hi, bus.lo}, 64'h0);
    chk("mid_rst_flags", {61'h0, bus.busy, bus.done, bus.div_zero}, 64'h0);
    run_op(1'b0, 1'b1, 32'd100, 32'd7, lat, bcnt);
    chk("div100_lat", lat, 34);
    chk("div100_res", {bus.hi, bus.lo}, {32'd2, 32'd14});
    run_op(1'b1, 1'b1, 32'd3, 32'd3, lat, bcnt);
    chk("both_lat", lat, 34);
    chk("both_res", {bus.hi, bus.lo}, {32'd0, 32'd9});
    run_op(1'b1, 1'b0, 32'd0, 32'd5, lat, bcnt);
`ifdef MDU_EARLY_ZERO_EN
    chk("zero_lat", lat, 2);
`else
    chk("zero_lat", lat, 34);
`endif
    chk("zero_res", {bus.hi, bus.lo}, 64'h0);
    @(posedge clk);
    #1;
    chk("done_pulse", bus.done, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
